// File: rtl/reg_file_pkg.sv
// Shared defaults for the two-write/two-read parameterised register file.
package reg_file_pkg;
   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 3;
   localparam int BYPASS_DEF   = 1;
   localparam int READ_REG_DEF = 0;
   localparam int ZERO_R0_DEF  = 0;
   localparam int NUM_RD       = 2;
endpackage

// File: rtl/reg_file_if.sv
// Write/read bus of the register file; the master drives writes and read addresses.
interface reg_file_if #(
   parameter int DATA_W = reg_file_pkg::DATA_W_DEF,
   parameter int ADDR_W = reg_file_pkg::ADDR_W_DEF
);
   logic              wr_a;
   logic [ADDR_W-1:0] wr_addr_a;
   logic [DATA_W-1:0] d_in_a;
   logic              wr_b;
   logic [ADDR_W-1:0] wr_addr_b;
   logic [DATA_W-1:0] d_in_b;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] d_out_a;
   logic [DATA_W-1:0] d_out_b;

   modport master (
      output wr_a, wr_addr_a, d_in_a, wr_b, wr_addr_b, d_in_b, rd_addr_a, rd_addr_b,
      input  d_out_a, d_out_b
   );
   modport slave (
      input  wr_a, wr_addr_a, d_in_a, wr_b, wr_addr_b, d_in_b, rd_addr_a, rd_addr_b,
      output d_out_a, d_out_b
   );
endinterface

// File: rtl/reg_file_rd_port.sv
// One read port: address mux, same-cycle write forwarding and optional output register.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int BYPASS   = BYPASS_DEF,
   parameter int READ_REG = READ_REG_DEF,
   parameter int ZERO_R0  = ZERO_R0_DEF
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
   input  logic                                wr_a,
   input  logic [ADDR_W-1:0]                   wr_addr_a,
   input  logic [DATA_W-1:0]                   d_in_a,
   input  logic                                wr_b,
   input  logic [ADDR_W-1:0]                   wr_addr_b,
   input  logic [DATA_W-1:0]                   d_in_b,
   input  logic [ADDR_W-1:0]                   rd_addr,
   output logic [DATA_W-1:0]                   d_out
);
   logic [DATA_W-1:0] rd_val;

   // Forwarding is gated by reset so a discarded write is never visible; B wins like storage.
   always_comb begin
      rd_val = regs[rd_addr];
      if (BYPASS != 0 && reset) begin
         if (wr_b && wr_addr_b == rd_addr)
            rd_val = d_in_b;
         else if (wr_a && wr_addr_a == rd_addr)
            rd_val = d_in_a;
      end
      if (ZERO_R0 != 0 && rd_addr == '0)
         rd_val = '0;
   end

   generate
      if (READ_REG != 0) begin : g_reg
         logic [DATA_W-1:0] d_q;
         always_ff @(posedge clk) begin
            if (!reset) d_q <= '0;
            else        d_q <= rd_val;
         end
         assign d_out = d_q;
      end else begin : g_comb
         assign d_out = rd_val;
      end
   endgenerate
endmodule

// File: rtl/reg_file_param.sv
// Parameterised 2-write/2-read register file; flop storage, port B wins write collisions.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int BYPASS   = BYPASS_DEF,
   parameter int READ_REG = READ_REG_DEF,
   parameter int ZERO_R0  = ZERO_R0_DEF
) (
   input logic        clk,
   input logic        reset,
   reg_file_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic                         we_a, we_b;

   assign we_a = bus.wr_a && !(ZERO_R0 != 0 && bus.wr_addr_a == '0);
   assign we_b = bus.wr_b && !(ZERO_R0 != 0 && bus.wr_addr_b == '0);

   // B is written last so it overrides A on an address collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         regs <= '0;
      end else begin
         if (we_a) regs[bus.wr_addr_a] <= bus.d_in_a;
         if (we_b) regs[bus.wr_addr_b] <= bus.d_in_b;
      end
   end

   reg_file_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .READ_REG(READ_REG), .ZERO_R0(ZERO_R0)
   ) u_rd_a (
      .clk(clk), .reset(reset), .regs(regs),
      .wr_a(bus.wr_a), .wr_addr_a(bus.wr_addr_a), .d_in_a(bus.d_in_a),
      .wr_b(bus.wr_b), .wr_addr_b(bus.wr_addr_b), .d_in_b(bus.d_in_b),
      .rd_addr(bus.rd_addr_a), .d_out(bus.d_out_a)
   );

   reg_file_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .READ_REG(READ_REG), .ZERO_R0(ZERO_R0)
   ) u_rd_b (
      .clk(clk), .reset(reset), .regs(regs),
      .wr_a(bus.wr_a), .wr_addr_a(bus.wr_addr_a), .d_in_a(bus.d_in_a),
      .wr_b(bus.wr_b), .wr_addr_b(bus.wr_addr_b), .d_in_b(bus.d_in_b),
      .rd_addr(bus.rd_addr_b), .d_out(bus.d_out_b)
   );
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads; 0 returns stored data.
REQ-004 SHALL have parameter READ_REG, default 0: 0 gives combinational reads; 1 gives registered reads with 1-cycle latency.
REQ-005 SHALL have parameter ZERO_R0, default 0: 1 hardwires register 0 to zero.
REQ-006 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  one clock; reset is synchronous and active-low.
REQ-008 SHALL have port wr_a  input  1  write enable, port A.
REQ-009 SHALL have port wr_addr_a  input  ADDR_W  write address, port A.
REQ-010 SHALL have port d_in_a  input  DATA_W  write data, port A.
REQ-011 SHALL have port wr_b  input  1  write enable, port B.
REQ-012 SHALL have port wr_addr_b  input  ADDR_W  write address, port B.
REQ-013 SHALL have port d_in_b  input  DATA_W  write data, port B.
REQ-014 SHALL have port rd_addr_a  input  ADDR_W  read address, read port A.
REQ-015 SHALL have port rd_addr_b  input  ADDR_W  read address, read port B.
REQ-016 SHALL have port d_out_a  output  DATA_W  read data, read port A.
REQ-017 SHALL have port d_out_b  output  DATA_W  read data, read port B.

Function
REQ-018 SHALL write d_in_x into register wr_addr_x at the rising clk edge when wr_x=1 and reset=1.
REQ-019 SHALL store only d_in_b when both write ports are enabled to the same address in one cycle (port B wins).
REQ-020 SHALL perform both writes in one cycle when the two write addresses differ.
REQ-021 SHALL, with READ_REG=0, drive d_out_x combinationally from the register at rd_addr_x.
REQ-022 SHALL, with READ_REG=1, register d_out_x at each rising edge, so data appears one cycle after the address is presented.
REQ-023 SHALL, with BYPASS=1, return the winning same-cycle write data (per REQ-019) when a read address matches an enabled write address; this covers both READ_REG settings.
REQ-024 SHALL, with BYPASS=0, return the value stored before the current edge on a read-write address collision.
REQ-025 SHALL, with ZERO_R0=1, ignore writes to address 0, return 0 on reads of address 0, and never bypass to address 0.
REQ-026 SHALL operate both read ports independently, including when both read the same address.
REQ-027 SHALL ignore X-free but disabled write data (wr_x=0), leaving storage unchanged.

Reset
REQ-028 SHALL clear every register to 0 at a rising edge with reset=0.
REQ-029 SHALL clear registered read outputs (READ_REG=1) to 0 while reset=0; combinational outputs then read 0 from cleared storage.
REQ-030 SHALL give reset priority over writes: a write asserted during reset is discarded.
REQ-031 SHALL accept writes on the first rising edge with reset=1 after a reset.

Structure
REQ-032 SHALL take parameter defaults (DATA_W, ADDR_W, BYPASS, READ_REG, ZERO_R0) from shared package reg_file_pkg.
REQ-033 SHALL implement each read port as one sub-module instance of reg_file_rd_port, which provides the address mux, bypass compare and optional output register; there SHALL be two instances.
REQ-034 SHALL synthesise storage as a flop array of 2**ADDR_W x DATA_W bits.

Verification
REQ-035 SHALL cover basic write/read with defaults: write 16'hcdef to r3, then 16'h3210 to r7; next cycle, rd_addr_a=3 and rd_addr_b=7 -> d_out_a=16'hcdef and d_out_b=16'h3210.
REQ-036 SHALL cover write collision: wr_a to r5 with 16'h4567 and wr_b to r5 with 16'hba98 in the same cycle -> r5 reads 16'hba98.
REQ-037 SHALL cover bypass: with BYPASS=1, wr_b to r1 with 16'h1234 while rd_addr_a=1 -> d_out_a=16'h1234 in the same cycle. With BYPASS=0, the same stimulus -> the old value, then 16'h1234 the next cycle.
REQ-038 SHALL cover registered reads: with READ_REG=1, change rd_addr_a from 3 to 7 -> d_out_a changes to r7 contents exactly one edge later.
REQ-039 SHALL cover ZERO_R0=1: write 16'hffff to r0 -> both read ports return 16'h0000 for address 0.
REQ-040 SHALL cover reset mid-operation: load r2=16'hbeef, assert reset=0 for one edge while wr_a writes r4 -> r2=0, r4=0 and outputs=0.
